// File: rtl/jelly_wishbone_arbiter_pkg.sv
// Shared types and helpers for the two-master WISHBONE arbiter.
package jelly_wishbone_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   // Width needed to hold a watchdog count of 0..cycles (at least one bit).
   function automatic int wd_width(input int cycles);
      return (cycles > 0) ? $clog2(cycles + 1) : 1;
   endfunction

endpackage

// File: rtl/jelly_wishbone_arbiter_rr.sv
// Two-input grant picker: single requester wins outright; a tie goes to the
// master that did not win last time, or always to master 0 in fixed mode.
module jelly_wishbone_arbiter_rr #(
   parameter int PRIORITY_MODE = 0
) (
   input  logic [1:0] request,
   input  logic       last_grant,
   output logic       grant
);

   // Combinational pick of the next owner.
   always_comb begin
      grant = 1'b0;
      if (request == 2'b11) begin
         grant = (PRIORITY_MODE != 0) ? 1'b0 : ~last_grant;
      end else if (request[1]) begin
         grant = 1'b1;
      end
   end

endmodule

// File: rtl/jelly_wishbone_arbiter.sv
// Two-master to one-slave WISHBONE arbiter with whole-transaction grants
// and a watchdog that force-acks transactions the slave never completes.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no owner; arbitrate among stb requests, grant on next edge
//   ST_BUSY | granted master drives the slave until ack, abort or timeout
module jelly_wishbone_arbiter
   import jelly_wishbone_arbiter_pkg::*;
#(
   parameter int                        WB_ADR_WIDTH   = 30,
   parameter int                        WB_DAT_WIDTH   = 32,
   parameter int                        WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
   parameter int                        PRIORITY_MODE  = 0,
   parameter int                        TIMEOUT_CYCLES = 255,
   parameter logic [WB_DAT_WIDTH-1:0]   TIMEOUT_DATA   = '1
) (
   input  logic                     clk,
   input  logic                     reset,

   input  logic [WB_ADR_WIDTH-1:0]  s_wb0_adr_i,
   input  logic [WB_DAT_WIDTH-1:0]  s_wb0_dat_i,
   input  logic                     s_wb0_we_i,
   input  logic [WB_SEL_WIDTH-1:0]  s_wb0_sel_i,
   input  logic                     s_wb0_stb_i,
   output logic [WB_DAT_WIDTH-1:0]  s_wb0_dat_o,
   output logic                     s_wb0_ack_o,

   input  logic [WB_ADR_WIDTH-1:0]  s_wb1_adr_i,
   input  logic [WB_DAT_WIDTH-1:0]  s_wb1_dat_i,
   input  logic                     s_wb1_we_i,
   input  logic [WB_SEL_WIDTH-1:0]  s_wb1_sel_i,
   input  logic                     s_wb1_stb_i,
   output logic [WB_DAT_WIDTH-1:0]  s_wb1_dat_o,
   output logic                     s_wb1_ack_o,

   output logic [WB_ADR_WIDTH-1:0]  m_wb_adr_o,
   output logic [WB_DAT_WIDTH-1:0]  m_wb_dat_o,
   output logic                     m_wb_we_o,
   output logic [WB_SEL_WIDTH-1:0]  m_wb_sel_o,
   output logic                     m_wb_stb_o,
   input  logic [WB_DAT_WIDTH-1:0]  m_wb_dat_i,
   input  logic                     m_wb_ack_i,

   output logic                     grant,
   output logic                     busy,
   output logic                     timeout_flag,
   input  logic                     timeout_clear
);

   localparam int                  WD_WIDTH = wd_width(TIMEOUT_CYCLES);
   localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);

   arb_state_t                 state;
   logic                       last_grant;
   logic [WD_WIDTH-1:0]        wd_count;
   logic                       next_grant;
   logic                       granted_stb;
   logic                       wd_expire;
   logic                       done;
   logic                       master_ack;
   logic [WB_DAT_WIDTH-1:0]    master_dat;

   jelly_wishbone_arbiter_rr #(
      .PRIORITY_MODE (PRIORITY_MODE)
   ) u_rr (
      .request    ({s_wb1_stb_i, s_wb0_stb_i}),
      .last_grant (last_grant),
      .grant      (next_grant)
   );

   assign busy        = (state == ST_BUSY);
   assign granted_stb = grant ? s_wb1_stb_i : s_wb0_stb_i;

   // The slave's own ack in the limit cycle takes precedence over the forced one.
   assign wd_expire = (TIMEOUT_CYCLES != 0) && busy && (wd_count == WD_LIMIT) && !m_wb_ack_i;
   assign done      = busy && (m_wb_ack_i || !granted_stb || wd_expire);

   assign m_wb_adr_o = grant ? s_wb1_adr_i : s_wb0_adr_i;
   assign m_wb_dat_o = grant ? s_wb1_dat_i : s_wb0_dat_i;
   assign m_wb_we_o  = grant ? s_wb1_we_i  : s_wb0_we_i;
   assign m_wb_sel_o = grant ? s_wb1_sel_i : s_wb0_sel_i;
   assign m_wb_stb_o = busy && granted_stb && !wd_expire;

   assign master_ack = busy && (m_wb_ack_i || wd_expire);
   assign master_dat = wd_expire ? TIMEOUT_DATA : m_wb_dat_i;

   assign s_wb0_ack_o = master_ack && !grant;
   assign s_wb1_ack_o = master_ack &&  grant;
   assign s_wb0_dat_o = grant ? '0 : master_dat;
   assign s_wb1_dat_o = grant ? master_dat : '0;

   // Transaction FSM: grant capture in IDLE, watchdog count and termination in BUSY.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         wd_count   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (s_wb0_stb_i || s_wb1_stb_i) begin
                  state      <= ST_BUSY;
                  grant      <= next_grant;
                  last_grant <= next_grant;
                  wd_count   <= '0;
               end
            end
            ST_BUSY: begin
               if (done) begin
                  state <= ST_IDLE;
               end else if (wd_count != WD_LIMIT) begin
                  wd_count <= wd_count + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Sticky timeout flag; a new timeout beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_flag <= 1'b0;
      end else if (wd_expire) begin
         timeout_flag <= 1'b1;
      end else if (timeout_clear) begin
         timeout_flag <= 1'b0;
      end
   end

endmodule
